m_muldiv_unit: RTL

Multi-cycle RISC-V M-extension execute unit that sits directly downstream of the M control decoder. It consumes the 6-bit ALU operation codes 20–32 (MUL through REMUW) together with the two execute-stage operands. Multiply-class ops complete in a fixed 2-cycle latency. Divide/remainder ops run on an iterative radix-2 restoring divider. The core pipeline stalls on `busy` and captures `result` when `result_valid` pulses.

---
 rtl/m_muldiv_unit_if.sv | 25 ++
 rtl/m_muldiv_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/m_muldiv_unit_if.sv
// Purpose: request/response bundle between the core execute stage and the M-extension unit.
// Latency: none; wires only.
// Backpressure: the core holds off new requests while busy is high; results are never stalled.
interface m_muldiv_unit_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  start;
    logic [5:0]            ALU_operation;
    logic [DATA_WIDTH-1:0] operand_A;
    logic [DATA_WIDTH-1:0] operand_B;
    logic                  flush;
    logic                  busy;
    logic                  result_valid;
    logic [DATA_WIDTH-1:0] result;

    modport master (
        output start, ALU_operation, operand_A, operand_B, flush,
        input  busy, result_valid, result
    );

    modport slave (
        input  start, ALU_operation, operand_A, operand_B, flush,
        output busy, result_valid, result
    );
endinterface

// File: rtl/m_muldiv_unit.sv
// Purpose: RISC-V M-extension execute unit (MUL*/DIV*/REM* and W variants), iterative restoring divider.
// Latency: multiply 2 cycles; divide N+2 cycles (N = 64 or 32); divide-by-zero/overflow 2 cycles.
// Backpressure: busy high while in flight, start ignored then; result_valid is a single-cycle pulse.
module m_muldiv_unit #(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 64,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           scan,
    m_muldiv_unit_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW + 1);

    localparam logic [5:0] OP_MUL    = 6'd20;
    localparam logic [5:0] OP_MULH   = 6'd21;
    localparam logic [5:0] OP_MULHU  = 6'd22;
    localparam logic [5:0] OP_MULHSU = 6'd23;
    localparam logic [5:0] OP_DIV    = 6'd24;
    localparam logic [5:0] OP_REM    = 6'd26;
    localparam logic [5:0] OP_REMU   = 6'd27;
    localparam logic [5:0] OP_MULW   = 6'd28;
    localparam logic [5:0] OP_DIVW   = 6'd29;
    localparam logic [5:0] OP_REMW   = 6'd31;
    localparam logic [5:0] OP_REMUW  = 6'd32;
    // W-ops only exist on a 64-bit datapath
    localparam logic [5:0] OP_LAST   = (DW == 64) ? OP_REMUW : OP_REMU;
    localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
    state_t state, state_d;

    function automatic logic [DW-1:0] sext32(input logic [DW-1:0] v);
        logic signed [DW-1:0] t;
        t = $signed(v << (DW - 32));
        return $unsigned(t >>> (DW - 32));
    endfunction

    function automatic logic [DW-1:0] zext32(input logic [DW-1:0] v);
        return (v << (DW - 32)) >> (DW - 32);
    endfunction

    logic [5:0]    op_q;
    logic [DW-1:0] a_q, b_q, quo, rem, dvsr, result_q;
    logic [CW-1:0] cnt;
    logic          neg_q, neg_r, dz_q, ovf_q;
    logic [31:0]   cycle;

    // Accept-time decode of the incoming request
    logic [5:0]    in_op;
    logic          in_w, in_mulc, in_sdiv, in_valid, in_dz, in_ovf, sign_a, sign_b, accept;
    logic [DW-1:0] a_ext, b_ext, abs_a, abs_b;

    always_comb begin
        in_op    = bus.ALU_operation;
        in_w     = (in_op >= OP_MULW);
        in_mulc  = (in_op <= OP_MULHSU) || (in_op == OP_MULW);
        in_sdiv  = (in_op == OP_DIV) || (in_op == OP_REM) || (in_op == OP_DIVW) || (in_op == OP_REMW);
        in_valid = (in_op >= OP_MUL) && (in_op <= OP_LAST);
        a_ext    = bus.operand_A;
        b_ext    = bus.operand_B;
        if (in_w) begin
            a_ext = in_sdiv ? sext32(bus.operand_A) : zext32(bus.operand_A);
            b_ext = in_sdiv ? sext32(bus.operand_B) : zext32(bus.operand_B);
        end
        sign_a   = in_sdiv & a_ext[DW-1];
        sign_b   = in_sdiv & b_ext[DW-1];
        abs_a    = sign_a ? -a_ext : a_ext;
        abs_b    = sign_b ? -b_ext : b_ext;
        in_dz    = (b_ext == '0);
        in_ovf   = in_sdiv && (b_ext == '1) && (in_w ? (a_ext[31:0] == 32'h8000_0000) : (a_ext == MIN_VAL));
        accept   = ((state == S_IDLE) || (state == S_DONE)) && bus.start && in_valid && !bus.flush;
    end

    // Full-width product with per-op operand signedness
    logic              mul_sa, mul_sb;
    logic signed [2*DW+1:0] ma, mb;
    logic [2*DW-1:0]   prod;
    logic [DW-1:0]     mul_res;

    always_comb begin
        mul_sa = (op_q == OP_MULH) || (op_q == OP_MULHSU);
        mul_sb = (op_q == OP_MULH);
        ma     = $signed({{(DW+2){mul_sa & a_q[DW-1]}}, a_q});
        mb     = $signed({{(DW+2){mul_sb & b_q[DW-1]}}, b_q});
        prod   = (2*DW)'(ma * mb);
        case (op_q)
            OP_MULH, OP_MULHU, OP_MULHSU: mul_res = prod[2*DW-1:DW];
            OP_MULW:                      mul_res = sext32(prod[DW-1:0]);
            default:                      mul_res = prod[DW-1:0];
        endcase
    end

    // Restoring divider step and final sign/corner-case fix-up
    logic [DW:0]   rem_sh, diff;
    logic [DW-1:0] fix_q, fix_r, fix_raw, fix_res;
    logic          is_rem_q, is_w_q;

    always_comb begin
        rem_sh   = {rem, quo[DW-1]};
        diff     = rem_sh - {1'b0, dvsr};
        is_rem_q = (op_q == OP_REM) || (op_q == OP_REMU) || (op_q == OP_REMW) || (op_q == OP_REMUW);
        is_w_q   = (op_q >= OP_MULW);
        fix_q    = dz_q ? '1 : (ovf_q ? a_q : (neg_q ? -quo : quo));
        fix_r    = dz_q ? a_q : (ovf_q ? '0 : (neg_r ? -rem : rem));
        fix_raw  = is_rem_q ? fix_r : fix_q;
        fix_res  = is_w_q ? sext32(fix_raw) : fix_raw;
    end

    // Next-state logic; flush overrides everything including a new start
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept)
                    state_d = in_mulc ? S_MUL : ((in_dz || in_ovf) ? S_FIX : S_DIV);
            end
            S_MUL:   state_d = S_DONE;
            S_DIV:   if (cnt == CW'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush)
            state_d = S_IDLE;
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_d;
    end

    // Operand capture, divider iteration and result register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q <= '0; a_q <= '0; b_q <= '0; quo <= '0; rem <= '0; dvsr <= '0;
            cnt <= '0; neg_q <= 1'b0; neg_r <= 1'b0; dz_q <= 1'b0; ovf_q <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= in_op;
            a_q   <= a_ext;
            b_q   <= b_ext;
            // W dividends are pre-aligned to the top so only 32 steps are needed
            quo   <= in_w ? (abs_a << (DW - 32)) : abs_a;
            rem   <= '0;
            dvsr  <= abs_b;
            cnt   <= in_w ? CW'(32) : CW'(DW);
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            dz_q  <= in_dz;
            ovf_q <= in_ovf;
        end else if (state == S_DIV) begin
            cnt <= cnt - CW'(1);
            if (!diff[DW]) begin
                rem <= diff[DW-1:0];
                quo <= {quo[DW-2:0], 1'b1};
            end else begin
                rem <= rem_sh[DW-1:0];
                quo <= {quo[DW-2:0], 1'b0};
            end
        end else if (!bus.flush && (state == S_MUL)) begin
            result_q <= mul_res;
        end else if (!bus.flush && (state == S_FIX)) begin
            result_q <= fix_res;
        end
    end

    // Free-running cycle counter for the scan window
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cycle <= '0;
        else        cycle <= cycle + 32'd1;
    end

    assign bus.busy         = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign bus.result_valid = (state == S_DONE);
    assign bus.result       = result_q;

`ifndef SYNTHESIS
    // Per-cycle debug trace inside the configured cycle window
    always @(posedge clock) begin
        if (scan && (int'(cycle) >= SCAN_CYCLES_MIN) && (int'(cycle) <= SCAN_CYCLES_MAX))
            $display("core%0d cyc=%0d state=%s busy=%b valid=%b result=%h",
                     CORE, cycle, state.name(), bus.busy, bus.result_valid, bus.result);
    end
`endif
endmodule
